// File: rtl/sprite_palette_bank.sv
// Multi-bank runtime-writable sprite palette with a registered index->RGB lookup,
// index-0 transparency and a frame-timed hit-flash that forces visible pixels white.
//
// state | meaning
// IDLE  | no flash, palette colours pass through
// FLASH | hit flash running, white on odd frames, frames_left counts down per frame_tick
module sprite_palette_bank #(
    parameter  int IDX_W        = 4,
    parameter  int NUM_BANKS    = 2,
    parameter  int COLOR_W      = 4,
    parameter  int FLASH_FRAMES = 8,
    localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_tick,
    input  logic                 pix_valid,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic [IDX_W-1:0]     index,
    input  logic                 wr_en,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic                 flash_start,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 out_valid,
    output logic                 transparent,
    output logic                 flash_active
);

    localparam int         NUM_ENT = 2 ** IDX_W;
    localparam logic [7:0] FLASH_N = 8'(FLASH_FRAMES);

    typedef enum logic [0:0] {IDLE, FLASH} state_t;

    function automatic logic [3*COLOR_W-1:0] grey_ramp(input int i);
        logic [COLOR_W-1:0] c;
        c = COLOR_W'(i);
        return {c, c, c};
    endfunction

    logic [3*COLOR_W-1:0] pal_q [NUM_BANKS][NUM_ENT];
    logic [3*COLOR_W-1:0] rgb_q;
    logic                 valid_q;
    logic                 transp_q;
    state_t               state_q, state_d;
    logic [7:0]           frames_q, frames_d;
    logic                 phase_q, phase_d;
    logic [BANK_W-1:0]    rd_bank;
    logic [3*COLOR_W-1:0] rd_data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < NUM_ENT; e++) begin
                    pal_q[b][e] <= grey_ramp(e);
                end
            end
        end else if (wr_en && (32'(wr_bank) < NUM_BANKS)) begin
            pal_q[wr_bank][wr_index] <= wr_data;
        end
    end

    // Out-of-range banks fall back to bank 0; the read sees pre-write contents.
    assign rd_bank = (32'(bank_sel) < NUM_BANKS) ? bank_sel : '0;
    assign rd_data = pal_q[rd_bank][index];

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        phase_d  = phase_q;
        case (state_q)
            IDLE: begin
                if (flash_start) begin
                    state_d  = FLASH;
                    frames_d = FLASH_N;
                    phase_d  = 1'b1;
                end
            end
            FLASH: begin
                if (flash_start) begin
                    frames_d = FLASH_N;
                    phase_d  = 1'b1;
                end else if (frame_tick) begin
                    if (frames_q == 8'd1) begin
                        state_d  = IDLE;
                        frames_d = 8'd0;
                        phase_d  = 1'b0;
                    end else begin
                        frames_d = frames_q - 8'd1;
                        phase_d  = ~phase_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            frames_q <= 8'd0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            phase_q  <= phase_d;
        end
    end

    // Lookup uses the phase being loaded at this same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q    <= '0;
            valid_q  <= 1'b0;
            transp_q <= 1'b0;
        end else begin
            valid_q <= pix_valid;
            if (pix_valid) begin
                transp_q <= (index == '0);
                rgb_q    <= (phase_d && (index != '0)) ? '1 : rd_data;
            end
        end
    end

    assign red          = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green        = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue         = rgb_q[COLOR_W-1:0];
    assign out_valid    = valid_q;
    assign transparent  = transp_q;
    assign flash_active = (state_q == FLASH);

endmodule
